symbol_byte_sender: RTL and testbench
=====================================

# symbol_byte_sender

Transmit-side counterpart of the receive-side digit decoder. It encodes a 2-bit display symbol code into the 8-bit line pattern that the receiver decodes, and feeds the UART transmitter through a valid/ready handshake. It sends bursts of one or more bytes with a programmable idle gap between them. It sits between the board's switch/button logic and the UART transmitter.

## Interface
Parameters:
- GAP_CYCLES, 16, idle clocks between successive bytes of one burst; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  burst request; sampled only in IDLE.
- sym  in  2  symbol code, captured on start: 0→8'hAA, 1→8'h55, 2→8'hCC, 3→8'h89.
- seq  in  1  captured on start.
  - 0: every byte of the burst is the encoding of the captured sym.
  - 1: bytes cycle AA, 55, CC, 89, AA, …, starting from the captured sym's position.
- rpt  in  3  captured on start; the burst length is rpt+1 bytes (1..8).
- tx_data  out  8  byte offered to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter can accept a byte this cycle.
- busy  out  1  a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- Encoding:
  - Symbol codes map to bytes as listed under sym.
  - The same 2-bit index drives tx_data, so no other byte value is ever produced.
- States:
  - IDLE:
    - tx_valid=0, busy=0.
    - On start=1, capture sym into idx, capture seq and rpt, load remaining=rpt, go to SEND.
  - SEND:
    - tx_valid=1, busy=1, tx_data=enc(idx).
    - A transfer occurs on a cycle with tx_valid=1 and tx_ready=1.
    - On transfer with remaining==0: go to IDLE and assert done for one cycle.
    - On transfer with remaining>0: decrement remaining; if seq=1, increment idx (2-bit, wraps 3→0); load gap counter = GAP_CYCLES; go to GAP.
    - Without a transfer, stay in SEND with tx_data held stable.
  - GAP:
    - tx_valid=0, busy=1.
    - Decrement the gap counter each cycle; when it reaches 0, go to SEND.
- start in SEND or GAP is ignored, with no queuing.
- Changes on sym, seq or rpt after capture have no effect on the running burst.
- tx_ready is ignored outside SEND.
- Reset:
  - State → IDLE immediately, asynchronously.
  - tx_valid=0, tx_data=8'h00, busy=0, done=0; idx, remaining and gap counter = 0.
  - A burst interrupted by reset is abandoned: no done pulse, and no byte is resent after release.

## Timing
- Start latency: start high at edge N → tx_valid=1 and busy=1 from edge N (registered outputs), visible in cycle N+1.
- tx_data and tx_valid are registered outputs.
  - tx_data changes only on entry to SEND.
  - tx_data is 8'h00 in IDLE.
- Byte spacing: transfer at edge A with more bytes remaining →
  - tx_valid=0 for exactly GAP_CYCLES cycles;
  - tx_valid=1 again at edge A+GAP_CYCLES+1.
- Burst completion: last transfer at edge A →
  - done=1 and busy=0 during cycle A+1 only;
  - a start sampled at edge A+1 is accepted.
- Back-pressure: if tx_ready stays low, tx_valid and tx_data hold indefinitely; there is no timeout.
- Minimum burst duration, with tx_ready tied high: (rpt+1) + rpt×GAP_CYCLES cycles from start to done.

## Test plan
- Single byte:
  - Stimulus: reset release, tx_ready=1, start with sym=2, seq=0, rpt=0.
  - Response: one transfer of 8'hCC in the cycle after start; done pulses once on the next cycle; busy is high for exactly 1 cycle.
- Repeat with gap:
  - Stimulus: GAP_CYCLES=4, sym=1, seq=0, rpt=2, tx_ready=1.
  - Response: three transfers of 8'h55, 5 cycles apart, then one done pulse.
- Sequence wrap:
  - Stimulus: sym=3, seq=1, rpt=4.
  - Response: bytes 89, AA, 55, CC, 89 in that order.
- Back-pressure:
  - Stimulus: hold tx_ready=0 for 10 cycles during SEND; also pulse start and change sym during the burst.
  - Response: tx_data is constant and tx_valid stays high; one transfer occurs when tx_ready rises; the mid-burst start and the sym change have no effect.
- Reset mid-burst:
  - Stimulus: assert reset during GAP of an rpt=3 burst.
  - Response: all outputs are 0 asynchronously; no done pulse; after release the block idles until a new start.
- Back-to-back bursts:
  - Stimulus: assert start in the done cycle.
  - Response: the new burst is accepted, with tx_valid=1 on the following cycle.

Source files
------------

// File: rtl/symbol_byte_sender.sv
// symbol_byte_sender
// Encodes a 2-bit display symbol into the line byte understood by the receive
// side digit decoder and offers bursts of such bytes to the UART transmitter
// over a valid/ready handshake, with a fixed idle gap between bytes.

module symbol_byte_sender #(
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sym,
  input  logic       seq,
  input  logic [2:0] rpt,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  state_t     state_r, state_s;
  logic [1:0] idx_r, idx_s;
  logic       seq_r, seq_s;
  logic [2:0] rem_r, rem_s;
  logic [7:0] gap_r, gap_s;
  logic [7:0] data_r, data_s;
  logic       valid_r, valid_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;

  // Symbol code to line byte; the 2-bit index makes any other byte impossible.
  function automatic logic [7:0] enc(input logic [1:0] code);
    logic [7:0] byte_v;
    case (code)
      2'd0:    byte_v = 8'hAA;
      2'd1:    byte_v = 8'h55;
      2'd2:    byte_v = 8'hCC;
      2'd3:    byte_v = 8'h89;
      default: byte_v = 8'hAA;
    endcase
    return byte_v;
  endfunction

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    seq_s   = seq_r;
    rem_s   = rem_r;
    gap_s   = gap_r;
    data_s  = data_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_s   = sym;
          seq_s   = seq;
          rem_s   = rpt;
          gap_s   = 8'd0;
          data_s  = enc(sym);
          valid_s = 1'b1;
          busy_s  = 1'b1;
          state_s = ST_SEND;
        end else begin
          data_s  = 8'h00;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (rem_r == 3'd0) begin
            // Last byte accepted: finish the burst with a single done pulse.
            data_s  = 8'h00;
            valid_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            rem_s   = rem_r - 3'd1;
            idx_s   = seq_r ? (idx_r + 2'd1) : idx_r;
            gap_s   = GAP_LOAD;
            valid_s = 1'b0;
            busy_s  = 1'b1;
            state_s = ST_GAP;
          end
        end else begin
          // Back-pressure: hold the offered byte unchanged.
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end
      end
      ST_GAP: begin
        // Reaching zero on this edge re-enters SEND so the gap is exactly
        // GAP_LOAD cycles of tx_valid low.
        if (gap_r <= 8'd1) begin
          gap_s   = 8'd0;
          data_s  = enc(idx_r);
          valid_s = 1'b1;
          busy_s  = 1'b1;
          state_s = ST_SEND;
        end else begin
          gap_s   = gap_r - 8'd1;
          valid_s = 1'b0;
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 2'd0;
        seq_s   = 1'b0;
        rem_s   = 3'd0;
        gap_s   = 8'd0;
        data_s  = 8'h00;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      seq_r   <= 1'b0;
      rem_r   <= 3'd0;
      gap_r   <= 8'd0;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      seq_r   <= seq_s;
      rem_r   <= rem_s;
      gap_r   <= gap_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign tx_data  = data_r;
  assign tx_valid = valid_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_symbol_byte_sender.sv
// Directed self-checking bench for symbol_byte_sender with GAP_CYCLES = 4.

module tb_symbol_byte_sender;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] sym;
  logic       seq;
  logic [2:0] rpt;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_d [16];
  int         got_t [16];
  int         got_n;
  int         done_t;
  int         busy_n;

  symbol_byte_sender #(.GAP_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sym      (sym),
    .seq      (seq),
    .rpt      (rpt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a burst and record transfers (sample index after the start edge)
  // until the done pulse is seen, bounded by a cycle budget.
  task automatic run_burst(input logic [1:0] s, input logic q, input logic [2:0] r);
    got_n  = 0;
    done_t = -1;
    busy_n = 0;
    sym = s; seq = q; rpt = r; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 200; t++) begin
      if (busy) busy_n++;
      if (tx_valid && tx_ready && got_n < 16) begin
        got_d[got_n] = tx_data;
        got_t[got_n] = t;
        got_n++;
      end
      if (done) begin
        done_t = t;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic [7:0] exp3 [5];
    int bad_n;
    exp3 = '{8'h89, 8'hAA, 8'h55, 8'hCC, 8'h89};

    reset = 1'b0; start = 1'b0; sym = 2'd0; seq = 1'b0; rpt = 3'd0; tx_ready = 1'b0;
    repeat (3) tick();
    chk("rst_data",  {24'd0, tx_data}, 32'h00);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    reset = 1'b1;
    tick();

    // Single byte
    tx_ready = 1'b1;
    run_burst(2'd2, 1'b0, 3'd0);
    chk("single_count", got_n, 32'd1);
    chk("single_data",  {24'd0, got_d[0]}, 32'hCC);
    chk("single_time",  got_t[0], 32'd1);
    chk("single_done",  done_t, 32'd2);
    chk("single_busy",  busy_n, 32'd1);
    chk("single_busy_at_done", {31'd0, busy}, 32'd0);
    tick();
    chk("single_done_once", {31'd0, done}, 32'd0);

    // Repeat with gap: three 55 bytes, 5 cycles apart
    run_burst(2'd1, 1'b0, 3'd2);
    chk("rep_count", got_n, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("rep_data", {24'd0, got_d[i]}, 32'h55);
      chk("rep_time", got_t[i], 32'(1 + 5 * i));
    end
    chk("rep_done", done_t, 32'd12);
    chk("rep_busy", busy_n, 32'd11);
    tick();
    chk("rep_done_once", {31'd0, done}, 32'd0);

    // Sequence wrap from symbol 3
    run_burst(2'd3, 1'b1, 3'd4);
    chk("wrap_count", got_n, 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("wrap_data", {24'd0, got_d[i]}, {24'd0, exp3[i]});
    end
    chk("wrap_done", done_t, 32'd22);
    tick();

    // Back-pressure with a mid-burst start and symbol change
    tx_ready = 1'b0;
    sym = 2'd0; seq = 1'b0; rpt = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, tx_valid}, 32'd1);
      chk("bp_data",  {24'd0, tx_data}, 32'hAA);
      if (i == 3) begin
        start = 1'b1; sym = 2'd3; seq = 1'b1; rpt = 3'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_gap_valid", {31'd0, tx_valid}, 32'd0);
    chk("bp_gap_busy",  {31'd0, busy}, 32'd1);
    repeat (3) tick();
    chk("bp_gap_end_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    chk("bp_second_valid", {31'd0, tx_valid}, 32'd1);
    chk("bp_second_data",  {24'd0, tx_data}, 32'hAA);
    tick();
    chk("bp_done", {31'd0, done}, 32'd1);
    tick();
    chk("bp_no_queue_busy",  {31'd0, busy}, 32'd0);
    chk("bp_no_queue_valid", {31'd0, tx_valid}, 32'd0);

    // Reset during GAP of an rpt=3 burst
    sym = 2'd0; seq = 1'b0; rpt = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_in_gap_busy",  {31'd0, busy}, 32'd1);
    chk("mid_in_gap_valid", {31'd0, tx_valid}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_data",  {24'd0, tx_data}, 32'h00);
    chk("mid_rst_done",  {31'd0, done}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    bad_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tx_valid || busy || done) bad_n++;
    end
    chk("mid_idle_after_release", bad_n, 32'd0);

    // Back-to-back: start in the done cycle
    sym = 2'd2; seq = 1'b0; rpt = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_first_data", {24'd0, tx_data}, 32'hCC);
    tick();
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    sym = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_second_valid", {31'd0, tx_valid}, 32'd1);
    chk("b2b_second_data",  {24'd0, tx_data}, 32'h55);
    chk("b2b_second_busy",  {31'd0, busy}, 32'd1);
    chk("b2b_second_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("b2b_second_done", {31'd0, done}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
